// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over oversample counts 6, 7 and 8.
module uart_rx_fifo #(
  parameter logic [7:0]  BAUD_DIV   = 8'h1A,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rxin,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_err,
  output logic               overrun,
  output logic [7:0]         Led
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } state_t;

  // Terminal count 2*BAUD_DIV+1 is just BAUD_DIV with a 1 appended.
  localparam logic [8:0]       BAUD_TERM = {BAUD_DIV, 1'b1};
  localparam logic [FIFO_AW:0] FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};

  logic                sync1_q, sync2_q, prev_q;
  state_t              state_q, state_d;
  logic [8:0]          baud_q, baud_d;
  logic [3:0]          os_q, os_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [7:0]          led_q, led_d;
  logic                frame_err_q, overrun_q;
  logic                fall_s, tick_s, mid_s, bit_s;
  logic                push_s, ferr_s, pop_s, full_s, wr_en_s, ovr_s;

  assign fall_s = prev_q & ~sync2_q;
  assign tick_s = (baud_q == BAUD_TERM);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_CNT = 4'd8;
  logic samp6_q, samp7_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Early votes at counts 6 and 7; the third vote is the live sample at count 8.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp6_q <= 1'b0;
      samp7_q <= 1'b0;
    end else begin
      if (tick_s && (os_q == 4'd6)) samp6_q <= sync2_q;
      if (tick_s && (os_q == 4'd7)) samp7_q <= sync2_q;
    end
  end

  assign bit_s = maj3(samp6_q, samp7_q, sync2_q);
`else
  localparam logic [3:0] DECIDE_CNT = 4'd7;
  assign bit_s = sync2_q;
`endif

  assign mid_s = tick_s && (os_q == DECIDE_CNT);

  // Synchronizer and edge-detect history; reset low so a start needs the line seen high first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rxin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver next-state: baud/oversample counters and frame sequencing.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    os_d    = os_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push_s  = 1'b0;
    ferr_s  = 1'b0;

    if (state_q == S_IDLE) begin
      baud_d = 9'd0;
      os_d   = 4'd0;
    end else if (tick_s) begin
      baud_d = 9'd0;
      os_d   = os_q + 4'd1;
    end else begin
      baud_d = baud_q + 9'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (fall_s) state_d = S_START;
        else        state_d = S_IDLE;
      end
      S_START: begin
        if (mid_s && bit_s) begin
          state_d = S_IDLE;
        end else if (mid_s) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (mid_s) begin
          shift_d = {bit_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               state_d = S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (mid_s) begin
          state_d = S_IDLE;
          if (bit_s) push_s = 1'b1;
          else       ferr_s = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a push into a full FIFO survives only when a pop frees the slot that cycle.
  always_comb begin
    pop_s    = rx_ready && (count_q != (FIFO_AW+1)'(0));
    full_s   = (count_q == FULL_CNT);
    wr_en_s  = push_s && (!full_s || pop_s);
    ovr_s    = push_s && full_s && !pop_s;
    wr_ptr_d = wr_en_s ? (wr_ptr_q + FIFO_AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s   ? (rd_ptr_q + FIFO_AW'(1)) : rd_ptr_q;
    led_d    = wr_en_s ? shift_q : led_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers for the receiver, FIFO and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= 9'd0;
      os_q        <= 4'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      mem_q       <= '{default: 8'h00};
      wr_ptr_q    <= FIFO_AW'(0);
      rd_ptr_q    <= FIFO_AW'(0);
      count_q     <= (FIFO_AW+1)'(0);
      led_q       <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      os_q        <= os_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      if (wr_en_s) mem_q[wr_ptr_q] <= shift_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      led_q       <= led_d;
      frame_err_q <= ferr_s;
      overrun_q   <= ovr_s;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != (FIFO_AW+1)'(0));
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign Led        = led_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame table plus hand sequences for latency, glitch,
// overrun, full-FIFO simultaneous push/pop and mid-frame reset. Uses a fast baud divisor.
module tb_uart_rx_fifo;

  localparam logic [7:0] BAUD_DIV_TB = 8'h03;
  localparam int BIT    = 32 * (int'(BAUD_DIV_TB) + 1);
  localparam int HALF   = BIT / 2;
  localparam int GAP    = 40;
  localparam int LAT_LO = 9 * BIT + HALF;
  localparam int LAT_HI = LAT_LO + 16;
  localparam int POP_AT = 9 * BIT + HALF + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic [7:0] Led;

  uart_rx_fifo #(.BAUD_DIV(BAUD_DIV_TB), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk(clk), .reset(reset), .rxin(rxin),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun), .Led(Led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;
  int lat_cyc;
  int f0, o0;

  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    if (overrun)   ovr_seen++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop;
    int         ferr;
    logic [4:0] cnt;
    logic [7:0] head;
    logic [7:0] led;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxin = f[i];
      step(BIT);
    end
    rxin = 1'b1;
    step(GAP);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0, 5'd1, 8'hA5, 8'hA5};
    vecs[1] = '{8'h5A, 1'b0, 1'b0, 1, 5'd0, 8'h00, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0, 5'd1, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0, 5'd1, 8'hFF, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1'b0, 0, 5'd1, 8'h81, 8'h81};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 0, 5'd2, 8'h81, 8'h7E};

    // Reset state and ignored pop on empty FIFO
    step(3);
    reset = 1'b0;
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_led", Led, 8'h00);
    pop_one();
    chk("empty_pop_count", fifo_count, 5'd0);
    chk("empty_pop_valid", rx_valid, 1'b0);
    step(10);

    // First byte and its latency from the start edge
    fork
      send_frame(8'h39, 1'b1);
      begin
        lat_cyc = 0;
        while (!rx_valid && lat_cyc < LAT_HI + 100) begin
          step(1);
          lat_cyc++;
        end
      end
    join
    n_cmp++;
    if (lat_cyc < LAT_LO || lat_cyc > LAT_HI) begin
      n_err++;
      $display("FAIL latency: got %0d clocks, want %0d..%0d", lat_cyc, LAT_LO, LAT_HI);
    end
    chk("b39_data", rx_data, 8'h39);
    chk("b39_led", Led, 8'h39);
    chk("b39_count", fifo_count, 5'd1);
    pop_one();
    chk("b39_pop_valid", rx_valid, 1'b0);
    chk("b39_pop_count", fifo_count, 5'd0);

    // Start glitch shorter than half a bit
    f0 = ferr_seen;
    rxin = 1'b0;
    step(HALF - 20);
    rxin = 1'b1;
    step(BIT);
    chk("glitch_valid", rx_valid, 1'b0);
    chk("glitch_ferr", ferr_seen - f0, 0);

    // Frame table
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_seen;
      send_frame(vecs[i].data, vecs[i].stop);
      chk($sformatf("vec%0d_ferr", i), ferr_seen - f0, vecs[i].ferr);
      chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].cnt);
      chk($sformatf("vec%0d_valid", i), rx_valid, (vecs[i].cnt != 5'd0));
      chk($sformatf("vec%0d_led", i), Led, vecs[i].led);
      if (vecs[i].cnt != 5'd0) chk($sformatf("vec%0d_head", i), rx_data, vecs[i].head);
      if (vecs[i].pop) begin
        pop_one();
        chk($sformatf("vec%0d_pop_count", i), fifo_count, vecs[i].cnt - 5'd1);
      end
    end
    chk("drain_head", rx_data, 8'h7E);
    pop_one();
    chk("drain_count", fifo_count, 5'd0);

    // Fill past full with no reads
    o0 = ovr_seen;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      chk($sformatf("fill%0d_count", i), fifo_count, (i < 16) ? (i + 1) : 16);
    end
    chk("full_overrun", ovr_seen - o0, 1);
    chk("full_led", Led, 8'h0F);
    chk("full_head", rx_data, 8'h00);

    // Pop on the exact edge the new byte lands while full
    o0 = ovr_seen;
    fork
      send_frame(8'h77, 1'b1);
      begin
        step(POP_AT);
        chk("simul_head", rx_data, 8'h00);
        chk("simul_count_pre", fifo_count, 5'd16);
        pop_one();
      end
    join
    chk("simul_overrun", ovr_seen - o0, 0);
    chk("simul_count", fifo_count, 5'd16);
    chk("simul_led", Led, 8'h77);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("read%0d", i), rx_data, (i < 15) ? (i + 1) : 8'h77);
      pop_one();
    end
    chk("read_empty_valid", rx_valid, 1'b0);

    // Reset during data bit 4 with a byte already queued
    send_frame(8'h11, 1'b1);
    chk("pre_rst_count", fifo_count, 5'd1);
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'hC3, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rxin = fr[i];
        step(BIT);
      end
      rxin = fr[5];
      step(HALF);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rxin = 1'b1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_count", fifo_count, 5'd0);
    chk("mid_rst_led", Led, 8'h00);
    f0 = ferr_seen;
    o0 = ovr_seen;
    step(2 * BIT);
    chk("post_rst_valid", rx_valid, 1'b0);
    chk("post_rst_ferr", ferr_seen - f0, 0);
    send_frame(8'h3C, 1'b1);
    chk("b3c_data", rx_data, 8'h3C);
    chk("b3c_count", fifo_count, 5'd1);
    chk("b3c_led", Led, 8'h3C);
    chk("b3c_no_pulses", (ferr_seen - f0) + (ovr_seen - o0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
